// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction width, R/I/J field
// bit positions and the {pc, instr} record carried by the fetch queue.
package mips_pkg;

  localparam int INSTR_W  = 32;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int JADDR_HI  = 25;
  localparam int JADDR_LO  = 0;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/mips_instr_fields.sv
// Purely combinational splitter of a MIPS instruction word into its
// opcode/register/shamt/funct/immediate/jump-target fields.
module mips_instr_fields
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0]           instr_i,
  output logic [OPCODE_HI-OPCODE_LO:0] opcode_o,
  output logic [RS_HI-RS_LO:0]         rs_o,
  output logic [RT_HI-RT_LO:0]         rt_o,
  output logic [RD_HI-RD_LO:0]         rd_o,
  output logic [SHAMT_HI-SHAMT_LO:0]   shamt_o,
  output logic [FUNCT_HI-FUNCT_LO:0]   funct_o,
  output logic [IMM_HI-IMM_LO:0]       imm_o,
  output logic [JADDR_HI-JADDR_LO:0]   jaddr_o
);

  assign opcode_o = instr_i[OPCODE_HI:OPCODE_LO];
  assign rs_o     = instr_i[RS_HI:RS_LO];
  assign rt_o     = instr_i[RT_HI:RT_LO];
  assign rd_o     = instr_i[RD_HI:RD_LO];
  assign shamt_o  = instr_i[SHAMT_HI:SHAMT_LO];
  assign funct_o  = instr_i[FUNCT_HI:FUNCT_LO];
  assign imm_o    = instr_i[IMM_HI:IMM_LO];
  assign jaddr_o  = instr_i[JADDR_HI:JADDR_LO];

endmodule

// File: rtl/mips_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of DEPTH {pc, instr}
// entries, head presented to decode with fields pre-split, cleared by
// flush or by the synchronous active-low reset.
// Optional feature: define MIPS_FETCH_QUEUE_BYPASS_EN to let an offered
// instruction reach decode in the same cycle when the queue is empty.
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [INSTR_W-1:0]       fetch_pc,
  input  logic [INSTR_W-1:0]       fetch_instr,
  output logic                     fetch_ready,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [INSTR_W-1:0]       dec_pc,
  output logic [INSTR_W-1:0]       dec_pc_plus4,
  output logic [INSTR_W-1:0]       dec_instr,
  output logic [5:0]               dec_opcode,
  output logic [4:0]               dec_rs,
  output logic [4:0]               dec_rt,
  output logic [4:0]               dec_rd,
  output logic [4:0]               dec_shamt,
  output logic [5:0]               dec_funct,
  output logic [15:0]              dec_imm,
  output logic [25:0]              dec_jaddr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head;

  logic q_valid;
  logic byp;
  logic push;
  logic pop;

  assign q_valid = (count_q != '0);

`ifdef MIPS_FETCH_QUEUE_BYPASS_EN
  // Empty queue with a consumer ready: hand the offer straight to decode.
  assign byp = !q_valid && fetch_valid && dec_ready && !flush;
`else
  assign byp = 1'b0;
`endif

  // fetch_ready deliberately ignores dec_ready: no decode-to-fetch path.
  assign fetch_ready = reset && (count_q != CW'(DEPTH));
  assign push        = fetch_valid && fetch_ready && !byp && !flush;
  assign pop         = q_valid && dec_ready;
  assign dec_valid   = q_valid || byp;
  assign count       = count_q;

  // Head selection: stored entry, bypassed offer, or all zeros when idle.
  always_comb begin
    head = '0;
    if (q_valid) begin
      head = mem_q[rd_ptr_q];
    end else if (byp) begin
      head.pc    = fetch_pc;
      head.instr = fetch_instr;
    end
  end

  assign dec_pc       = head.pc;
  assign dec_instr    = head.instr;
  assign dec_pc_plus4 = dec_valid ? (head.pc + 32'd4) : '0;

  mips_instr_fields u_fields (
    .instr_i  (head.instr),
    .opcode_o (dec_opcode),
    .rs_o     (dec_rs),
    .rt_o     (dec_rt),
    .rd_o     (dec_rd),
    .shamt_o  (dec_shamt),
    .funct_o  (dec_funct),
    .imm_o    (dec_imm),
    .jaddr_o  (dec_jaddr)
  );

  // Pointer/occupancy next state; reset and flush override push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clock) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Entry storage: written on push only, never reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: fetch_pc, instr: fetch_instr};
    end
  end

endmodule
